// File: rtl/serial_vartheta_inv.sv
// Inverse vartheta layer for the SWAN64 serial decryption datapath.
// A half-block is split MSB-first into four columns c0..c3. Columns c0, c1 and c2
// are rotated left by PC, PB and PA respectively, one column per cycle.
// Bit 0 of x/y is the MSB, so vectors are declared ascending [0:SIDE_SIZE-1].
//
// Handshake contract (both sides): a transfer happens on a rising edge where
// valid && ready are both high. Once out_valid is raised it stays high, with y
// stable, until out_ready is seen. in_valid is ignored whenever in_ready is low.
module serial_vartheta_inv #(
  parameter int BLOCK_SIZE  = 64,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int PA          = 1,
  parameter int PB          = 2,
  parameter int PC          = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:SIDE_SIZE-1] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:SIDE_SIZE-1] y,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CS = COLUMN_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [0:SIDE_SIZE-1] work_q, work_d;
  logic [0:SIDE_SIZE-1] res_q, res_d;
  logic [0:SIDE_SIZE-1] y_q, y_d;
  logic                 out_valid_q, out_valid_d;
  logic                 init_q;

  logic [0:CS-1]        col0, col1, col2, col3;
  logic [0:CS-1]        rot0, rot1, rot2;
  logic [0:SIDE_SIZE-1] res_next;

  // Column slices of the work register and their constant left rotations.
  assign col0 = work_q[0*CS +: CS];
  assign col1 = work_q[1*CS +: CS];
  assign col2 = work_q[2*CS +: CS];
  assign col3 = work_q[3*CS +: CS];
  assign rot0 = {col0[PC:CS-1], col0[0:PC-1]};
  assign rot1 = {col1[PB:CS-1], col1[0:PB-1]};
  assign rot2 = {col2[PA:CS-1], col2[0:PA-1]};

  // in_ready stays low until the first edge after reset release (init_q).
  assign in_ready  = init_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = (state_q == BUSY);
  assign dbg_state = state_q;

  // Result register with the current column (selected by cnt) replaced.
  always_comb begin
    res_next = res_q;
    case (cnt_q)
      2'd0:    res_next[0*CS +: CS] = rot0;
      2'd1:    res_next[1*CS +: CS] = rot1;
      2'd2:    res_next[2*CS +: CS] = rot2;
      default: res_next[3*CS +: CS] = col3;
    endcase
  end

  // Next-state and datapath updates for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    res_d       = res_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = x;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d = res_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          y_d         = res_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            // Output and input handshakes complete on the same edge.
            work_d  = x;
            cnt_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight half-block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      work_q      <= '0;
      res_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      res_q       <= res_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      init_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_vartheta_inv.sv
// Bench for serial_vartheta_inv: directed vectors plus a randomised handshake run,
// checked against a byte-rotation model of the inverse and forward vartheta.
module tb_serial_vartheta_inv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic prev_ov = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];
  int          acc_q[$];

  serial_vartheta_inv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: byte-wise rotations, c0 is the most significant byte.
  function automatic logic [7:0] rol8(input logic [7:0] v, input int p);
    return 8'((v << p) | (v >> (8 - p)));
  endfunction

  function automatic logic [31:0] inv_model(input logic [31:0] v);
    return {rol8(v[31:24], 7), rol8(v[23:16], 2), rol8(v[15:8], 1), v[7:0]};
  endfunction

  function automatic logic [31:0] fwd_model(input logic [31:0] v);
    return {rol8(v[31:24], 1), rol8(v[23:16], 6), rol8(v[15:8], 7), v[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: records accepted inputs and checks every visible output.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      src_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got y=%h expected no output", y);
        end else begin
          check("y_vs_model", y, exp_q[0]);
          check("fwd_of_y_vs_x", fwd_model(y), src_q[0]);
          if (!prev_ov) check("latency", 32'(cyc - acc_q[0]), 32'd5);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(src_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(inv_model(x));
        src_q.push_back(x);
        acc_q.push_back(cyc);
      end
      prev_ov = out_valid;
    end
  end

  // Driver tasks
  task automatic drive_x(input logic [31:0] v);
    bit ok = 0;
    in_valid = 1'b1;
    x        = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready never seen for x=%h", v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL output_timeout: out_valid never seen");
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Directed and random stimulus
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0;

    // Model pins
    check("pin_inv_80808080", inv_model(32'h80808080), 32'h40020180);
    check("pin_inv_01020304", inv_model(32'h01020304), 32'h80080604);
    check("pin_inv_deadbeef", inv_model(32'hdeadbeef), 32'h6fb67def);
    check("pin_roundtrip", fwd_model(inv_model(32'h13579bdf)), 32'h13579bdf);

    // Reset values
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_y", y, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // T2
    drive_x(32'h80808080);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_valid();
    check("t2_y", y, 32'h40020180);
    check("t2_out_valid", {31'd0, out_valid}, 32'd1);
    take_out();
    check("t2_valid_dropped", {31'd0, out_valid}, 32'd0);
    check("t2_y_retained", y, 32'h40020180);

    // T3
    drive_x(32'h01020304);
    wait_valid();
    check("t3_y", y, 32'h80080604);
    take_out();

    // T1: asynchronous reset mid-BUSY
    drive_x(32'hcafef00d);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_y", y, 32'd0);
    check("t1_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_in_ready_release", {31'd0, in_ready}, 32'd1);
    drive_x(32'hdeadbeef);
    wait_valid();
    check("t1_next_y", y, 32'h6fb67def);
    take_out();

    // T4: backpressure then same-cycle turnaround
    drive_x(32'ha1b2c3d4);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; x = 32'h0f1e2d3c;
    @(negedge clk);
    check("t4_in_ready_turnaround", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("t4_busy_again", {31'd0, busy}, 32'd1);
    wait_valid();
    check("t4_second_y", y, inv_model(32'h0f1e2d3c));
    take_out();

    // T5: in_valid during BUSY is ignored
    drive_x(32'h11223344);
    @(posedge clk); #1;
    in_valid = 1'b1; x = 32'h55667788;
    repeat (2) begin
      @(negedge clk);
      check("t5_in_ready_busy", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid();
    check("t5_y", y, inv_model(32'h11223344));
    take_out();
    repeat (8) begin
      @(negedge clk);
      check("t5_no_extra_output", {31'd0, out_valid}, 32'd0);
    end
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // T6: random traffic
    begin
      int n_acc = 0;
      while (n_acc < 2000) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        x         = $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (in_valid && in_ready) n_acc++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_idle_after_drain", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
